bus_slave_mem_port: RTL and testbench

- Serial-bus memory slave: the downstream consumer of bus_bridge_master traffic once the arbiter/decoder has stripped the slave-select bits.
- Deserialises the address and write data, which arrive LSB-first, one bit per mvalid cycle.
- Writes go to an internal synchronous RAM.
- Reads are serialised back on srdata/svalid.
- Replaces the behavioural slave model in system-level benches; used as the memory slave in the top-level bus.

---
 rtl/bus_slave_pkg.sv | 15 +
 rtl/slave_bram.sv | 24 ++
 rtl/bus_slave_mem_port.sv | 163 ++++++++++++++++
 tb/tb_bus_slave_mem_port.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_pkg.sv
// Shared types and constants for the serial-bus memory slave.
package bus_slave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        RLAT  = 3'd3,
        RDATA = 3'd4
    } slave_state_t;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

endpackage

// File: rtl/slave_bram.sv
// Single-port synchronous RAM with a one-cycle registered read and no reset,
// shaped so it can be swapped for a vendor block RAM.
module slave_bram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write when enabled; read-first registered output every cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_slave_mem_port.sv
// Serial-bus memory slave: address and write data arrive LSB-first, one bit
// per mvalid cycle; read data is returned LSB-first on srdata/svalid.
// Optional macro SLAVE_RD_WAIT_EN stretches the read latency by READ_WAIT cycles.
module bus_slave_mem_port
    import bus_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int READ_WAIT  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic swdata,
    input  logic smode,
    input  logic mvalid,
    output logic srdata,
    output logic svalid,
    output logic sready
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int BIT_W   = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_WIDTH);

    slave_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    // Only DATA_WIDTH-1 bits are stored; the final bit goes straight to the RAM.
    logic [DATA_WIDTH-2:0] data_q, data_d;
    logic                  srdata_q, srdata_d;
    logic                  svalid_q, svalid_d;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  rlat_done;

    assign ram_wdata = {swdata, data_q};
    assign srdata    = srdata_q;
    assign svalid    = svalid_q;
    assign sready    = (state_q == IDLE);

`ifdef SLAVE_RD_WAIT_EN
    localparam int              WAIT_W    = $clog2(READ_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT);

    logic [WAIT_W-1:0] wait_q;

    // Count cycles spent in RLAT; cleared everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (state_q == RLAT && !rlat_done) begin
            wait_q <= wait_q + WAIT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end

    assign rlat_done = (wait_q == WAIT_LAST);
`else
    // RLAT is a single cycle; READ_WAIT has no effect in this build.
    assign rlat_done = 1'b1 | (READ_WAIT == 0);
`endif

    // Transfer sequencing: shift in address/data, commit writes, stream reads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        srdata_d = srdata_q;
        svalid_d = svalid_q;
        ram_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mvalid) begin
                    addr_d  = {swdata, addr_q[ADDR_WIDTH-1:1]};
                    cnt_d   = CNT_W'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (mvalid) begin
                    addr_d = {swdata, addr_q[ADDR_WIDTH-1:1]};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = (smode == MODE_WRITE) ? WDATA : RLAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WDATA: begin
                if (mvalid) begin
                    if (cnt_q == DATA_LAST) begin
                        ram_we  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        data_d = {swdata, data_q[DATA_WIDTH-2:1]};
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            RLAT: begin
                if (rlat_done) begin
                    cnt_d   = '0;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (cnt_q == DATA_END) begin
                    svalid_d = 1'b0;
                    srdata_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    svalid_d = 1'b1;
                    srdata_d = ram_rdata[cnt_q[BIT_W-1:0]];
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer and drops svalid at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            srdata_q <= 1'b0;
            svalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            srdata_q <= srdata_d;
            svalid_q <= svalid_d;
        end
    end

    slave_bram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr_q),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_bus_slave_mem_port.sv
// Self-checking bench for bus_slave_mem_port: a transaction-level memory model
// builds a per-cycle timeline of expected sready/svalid/srdata, checked every cycle.
module tb_bus_slave_mem_port;

`ifdef SLAVE_RD_WAIT_EN
    localparam int W = 4;
`else
    localparam int W = 0;
`endif
    localparam int DW = 8;

    logic clk, rst, swdata, smode, mvalid;
    logic srdata, svalid, sready;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit run    = 0;

    logic [7:0] model_mem [logic [11:0]];
    bit         exp_rdy [int];
    bit         exp_vld [int];
    bit         exp_dat [int];

    bus_slave_mem_port #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(8),
        .READ_WAIT (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .swdata(swdata),
        .smode (smode),
        .mvalid(mvalid),
        .srdata(srdata),
        .svalid(svalid),
        .sready(sready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the timeline model (defaults: idle, no response).
    always @(negedge clk) begin
        if (run) begin
            chk("sready", {31'd0, sready}, {31'd0, exp_rdy.exists(cyc) ? exp_rdy[cyc] : 1'b1});
            chk("svalid", {31'd0, svalid}, {31'd0, exp_vld.exists(cyc) ? exp_vld[cyc] : 1'b0});
            chk("srdata", {31'd0, srdata}, {31'd0, exp_dat.exists(cyc) ? exp_dat[cyc] : 1'b0});
        end
    end

    function automatic logic [7:0] mem_rd(input logic [11:0] a);
        return model_mem.exists(a) ? model_mem[a] : 8'h00;
    endfunction

    task automatic send_bit(input logic b, input logic m, input bit gap, input bit busy_after);
        mvalid = 1'b1;
        swdata = b;
        smode  = m;
        @(posedge clk);
        #1;
        if (busy_after) exp_rdy[cyc] = 1'b0;
        mvalid = 1'b0;
        swdata = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
            if (busy_after) exp_rdy[cyc] = 1'b0;
        end
    endtask

    task automatic xfer_addr(input logic [11:0] a, input logic early_mode, input logic last_mode,
                             input bit gap);
        for (int i = 0; i < 12; i++) begin
            send_bit(a[i], (i == 11) ? last_mode : early_mode, gap, 1'b1);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input bit gap);
        xfer_addr(a, 1'b1, 1'b1, gap);
        for (int i = 0; i < DW; i++) send_bit(d[i], 1'b1, gap, i != DW - 1);
        model_mem[a] = d;
    endtask

    task automatic do_read(input logic [11:0] a, input logic early_mode,
                           output logic [7:0] word, output int lat);
        int         last;
        int         nb;
        logic [7:0] v;
        logic [7:0] w;
        xfer_addr(a, early_mode, 1'b0, 1'b0);
        last = cyc;
        v    = mem_rd(a);
        // Busy from last address bit until the cycle after the final data bit.
        for (int i = 0; i <= 1 + W + DW; i++) exp_rdy[last + i] = 1'b0;
        for (int i = 0; i < DW; i++) begin
            exp_vld[last + 2 + W + i] = 1'b1;
            exp_dat[last + 2 + W + i] = v[i];
        end
        w   = '0;
        nb  = 0;
        lat = -1;
        for (int k = 0; k < 40 && nb < DW; k++) begin
            @(negedge clk);
            if (svalid === 1'b1) begin
                if (lat < 0) lat = cyc - last;
                w[nb] = srdata;
                nb++;
            end
        end
        chk("rd_bits_seen", nb, DW);
        word = w;
        while (cyc < last + 2 + W + DW) begin
            @(posedge clk);
            #1;
        end
        chk("rdy_after_read", {31'd0, sready}, 32'd1);
    endtask

    initial begin
        logic [7:0] word;
        int         lat;
        logic [7:0] part;
        rst    = 1'b1;
        swdata = 1'b0;
        smode  = 1'b0;
        mvalid = 1'b0;
        run    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sready", {31'd0, sready}, 32'd1);
        chk("rst_svalid", {31'd0, svalid}, 32'd0);
        chk("rst_srdata", {31'd0, srdata}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Contiguous write then read back: LSB-first 0,1,1,1,1,0,1,1.
        do_write(12'h055, 8'hDE, 1'b0);
        do_read(12'h055, 1'b0, word, lat);
        chk("rd055_data", {24'd0, word}, 32'h0000_00DE);
        chk("rd055_lat", lat, 2 + W);

        // Never-written location reads as zero.
        do_read(12'h222, 1'b0, word, lat);
        chk("rd222_data", {24'd0, word}, 32'h0000_0000);

        // Top address with mvalid toggling every cycle.
        do_write(12'hFFF, 8'h4B, 1'b1);
        do_read(12'hFFF, 1'b0, word, lat);
        chk("rdFFF_data", {24'd0, word}, 32'h0000_004B);

        // smode only matters on the last address bit: this is a read.
        do_write(12'h3C3, 8'hA5, 1'b0);
        do_read(12'h3C3, 1'b1, word, lat);
        chk("mode_trap_data", {24'd0, word}, 32'h0000_00A5);
        do_read(12'h3C3, 1'b0, word, lat);
        chk("mode_trap_again", {24'd0, word}, 32'h0000_00A5);

        // Reset half-way through a write leaves the old contents.
        do_write(12'h010, 8'h33, 1'b0);
        part = 8'hC4;
        xfer_addr(12'h010, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(part[i], 1'b1, 1'b0, 1'b1);
        exp_rdy.delete(cyc);
        rst = 1'b1;
        #1;
        chk("abort_svalid", {31'd0, svalid}, 32'd0);
        chk("abort_sready", {31'd0, sready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_read(12'h010, 1'b0, word, lat);
        chk("abort_rd_data", {24'd0, word}, 32'h0000_0033);

        repeat (3) @(posedge clk);
        #1;
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
